// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timekeeping core: control states,
// counter moduli and field widths.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  localparam int MSEC_MAX = 100;
  localparam int SEC_MAX  = 60;
  localparam int MIN_MAX  = 60;

  localparam int W_MSEC = 7;
  localparam int W_SEC  = 6;
  localparam int W_MIN  = 6;

endpackage

// File: rtl/tick_gen_100hz.sv
// Divides the system clock down to a one-cycle tick every FCOUNT enabled cycles.
// The divider holds while disabled so a partial interval survives a stop.
module tick_gen_100hz #(
  parameter int FCOUNT = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int              W_DIV    = $clog2(FCOUNT);
  localparam logic [W_DIV-1:0] DIV_LAST = W_DIV'(FCOUNT - 1);

  logic [W_DIV-1:0] div_r;
  logic [W_DIV-1:0] div_nxt_s;
  logic             tick_nxt_s;

  // Next divider value and tick decision
  always_comb begin
    div_nxt_s  = div_r;
    tick_nxt_s = 1'b0;
    if (i_clr) begin
      div_nxt_s = '0;
    end else if (i_en) begin
      if (div_r == DIV_LAST) begin
        div_nxt_s  = '0;
        tick_nxt_s = 1'b1;
      end else begin
        div_nxt_s = div_r + 1'b1;
      end
    end else begin
      div_nxt_s = div_r;
    end
  end

  // Divider and tick registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r  <= '0;
      o_tick <= 1'b0;
    end else begin
      div_r  <= div_nxt_s;
      o_tick <= tick_nxt_s;
    end
  end

endmodule

// File: rtl/stopwatch_datapath.sv
// Stopwatch core: run/stop/clear control, 100 Hz tick gating and the
// cascaded centisecond / second / minute counters.
module stopwatch_datapath #(
  parameter int FCOUNT   = 1_000_000,
  parameter int MSEC_MAX = stopwatch_pkg::MSEC_MAX,
  parameter int SEC_MAX  = stopwatch_pkg::SEC_MAX,
  parameter int MIN_MAX  = stopwatch_pkg::MIN_MAX
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_btn_run,
  input  logic                              i_btn_clear,
  output logic [stopwatch_pkg::W_MSEC-1:0]  o_msec,
  output logic [stopwatch_pkg::W_SEC-1:0]   o_sec,
  output logic [stopwatch_pkg::W_MIN-1:0]   o_min,
  output logic                              o_run,
  output logic                              o_tick
);

  import stopwatch_pkg::*;

  localparam logic [W_MSEC-1:0] MSEC_LAST = W_MSEC'(MSEC_MAX - 1);
  localparam logic [W_SEC-1:0]  SEC_LAST  = W_SEC'(SEC_MAX - 1);
  localparam logic [W_MIN-1:0]  MIN_LAST  = W_MIN'(MIN_MAX - 1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [W_MSEC-1:0] msec_nxt_s;
  logic [W_SEC-1:0]  sec_nxt_s;
  logic [W_MIN-1:0]  min_nxt_s;

  // Control FSM next state; clear wins over run while stopped
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_STOP: begin
        if (i_btn_clear) begin
          state_nxt_s = ST_CLEAR;
        end else if (i_btn_run) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      ST_RUN: begin
        if (i_btn_run) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_CLEAR: state_nxt_s = ST_STOP;
      default:  state_nxt_s = ST_STOP;
    endcase
  end

  // State register; o_run tracks the state it is entering
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_STOP;
      o_run   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      o_run   <= (state_nxt_s == ST_RUN);
    end
  end

  tick_gen_100hz #(
    .FCOUNT (FCOUNT)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .i_en   (state_r == ST_RUN),
    .i_clr  (state_r == ST_CLEAR),
    .o_tick (o_tick)
  );

  // Cascaded counters advance off the registered tick, independent of state,
  // so a tick registered just before a stop is still counted
  always_comb begin
    msec_nxt_s = o_msec;
    sec_nxt_s  = o_sec;
    min_nxt_s  = o_min;
    if (state_r == ST_CLEAR) begin
      msec_nxt_s = '0;
      sec_nxt_s  = '0;
      min_nxt_s  = '0;
    end else if (o_tick) begin
      if (o_msec == MSEC_LAST) begin
        msec_nxt_s = '0;
        if (o_sec == SEC_LAST) begin
          sec_nxt_s = '0;
          min_nxt_s = (o_min == MIN_LAST) ? '0 : o_min + 1'b1;
        end else begin
          sec_nxt_s = o_sec + 1'b1;
        end
      end else begin
        msec_nxt_s = o_msec + 1'b1;
      end
    end else begin
      msec_nxt_s = o_msec;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_msec <= '0;
      o_sec  <= '0;
      o_min  <= '0;
    end else begin
      o_msec <= msec_nxt_s;
      o_sec  <= sec_nxt_s;
      o_min  <= min_nxt_s;
    end
  end

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Self-checking bench for stopwatch_datapath: a timing vector table on a
// FCOUNT=10 instance plus directed sequences on FCOUNT=2 instances.
module tb_stopwatch_datapath;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       run10, clr10, run2, clr2, runs, clrs;
  logic [6:0] msec10, msec2, msecs;
  logic [5:0] sec10, sec2, secs;
  logic [5:0] min10, min2, mins;
  logic       orun10, orun2, oruns;
  logic       tick10, tick2, ticks;

  stopwatch_datapath #(.FCOUNT(10)) u10 (
    .clk(clk), .reset(reset), .i_btn_run(run10), .i_btn_clear(clr10),
    .o_msec(msec10), .o_sec(sec10), .o_min(min10), .o_run(orun10), .o_tick(tick10)
  );

  stopwatch_datapath #(.FCOUNT(2)) u2 (
    .clk(clk), .reset(reset), .i_btn_run(run2), .i_btn_clear(clr2),
    .o_msec(msec2), .o_sec(sec2), .o_min(min2), .o_run(orun2), .o_tick(tick2)
  );

  // Reduced moduli so a full 59:59.99-style wrap fits in a short run
  stopwatch_datapath #(.FCOUNT(2), .MSEC_MAX(4), .SEC_MAX(3), .MIN_MAX(3)) us (
    .clk(clk), .reset(reset), .i_btn_run(runs), .i_btn_clear(clrs),
    .o_msec(msecs), .o_sec(secs), .o_min(mins), .o_run(oruns), .o_tick(ticks)
  );

  typedef struct {
    logic run;
    logic clr;
    logic exp_run;
    logic exp_tick;
    int   exp_msec;
  } vec_t;

  localparam int NVEC = 88;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pack(input int m, input int s, input int mi);
    return (mi << 13) | (s << 7) | m;
  endfunction

  function automatic int vals(input int sel);
    if (sel == 0) return pack(int'(msec2), int'(sec2), int'(min2));
    else          return pack(int'(msecs), int'(secs), int'(mins));
  endfunction

  // Wait (bounded) until the selected instance shows m/s/mi at a negedge
  task automatic wait_vals(input int sel, input int m, input int s, input int mi,
                           input int budget, input string name);
    int n;
    n = 0;
    while (vals(sel) != pack(m, s, mi) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_reached"}, int'(n < budget), 1);
  endtask

  // Two cycles after a counter change the next change is visible (FCOUNT=2)
  task automatic step_expect(input int sel, input int m, input int s, input int mi,
                             input string name);
    @(negedge clk);
    @(negedge clk);
    check(name, vals(sel), pack(m, s, mi));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    {run10, clr10, run2, clr2, runs, clrs} = 6'b0;

    // Reset held with buttons toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_hold_u10", int'({msec10, sec10, min10, orun10, tick10}), 0);
      check("rst_hold_u2",  int'({msec2, sec2, min2, orun2, tick2}), 0);
      run10 = i[0];  clr10 = ~i[0];
      run2  = ~i[0]; clr2  = i[0];
      runs  = i[0];  clrs  = i[1];
    end
    @(negedge clk);
    {run10, clr10, run2, clr2, runs, clrs} = 6'b0;
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_u10", int'({msec10, sec10, min10, orun10, tick10}), 0);
      check("idle_us",  int'({msecs, secs, mins, oruns, ticks}), 0);
    end

    // Run timing table (FCOUNT=10): run at 0, clear ignored at 73, stop at 86
    for (int k = 0; k < NVEC; k++) begin
      vecs[k].run      = (k == 0 || k == 86);
      vecs[k].clr      = (k == 73);
      vecs[k].exp_run  = (k >= 1 && k <= 86);
      vecs[k].exp_tick = (k >= 11 && k <= 86 && (k - 1) % 10 == 0);
      vecs[k].exp_msec = (k >= 2) ? (k - 2) / 10 : 0;
    end
    for (int k = 0; k < NVEC; k++) begin
      @(negedge clk);
      check($sformatf("vec%0d_run", k),  int'(orun10), int'(vecs[k].exp_run));
      check($sformatf("vec%0d_tick", k), int'(tick10), int'(vecs[k].exp_tick));
      check($sformatf("vec%0d_msec", k), int'(msec10), vecs[k].exp_msec);
      run10 = vecs[k].run;
      clr10 = vecs[k].clr;
    end

    // Stopped at 8: clear takes effect two cycles after the pulse
    @(negedge clk);
    check("stop_hold_msec", int'(msec10), 8);
    clr10 = 1'b1;
    @(negedge clk);
    clr10 = 1'b0;
    check("clear_lat_msec", int'(msec10), 8);
    @(negedge clk);
    check("clear_zero", int'({msec10, sec10, min10}), 0);
    check("clear_run", int'(orun10), 0);

    // Run 4 cycles, stop, idle 100 cycles, resume: tick 6 cycles after o_run
    run10 = 1'b1;
    @(negedge clk);
    run10 = 1'b0;
    check("resume_run1", int'(orun10), 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    run10 = 1'b1;
    @(negedge clk);
    run10 = 1'b0;
    check("partial_stop", int'(orun10), 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("partial_hold", int'({msec10, tick10, orun10}), 0);
    end
    run10 = 1'b1;
    @(negedge clk);
    run10 = 1'b0;
    check("resume_run2", int'(orun10), 1);
    check("resume_tick0", int'(tick10), 0);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check($sformatf("resume_notick%0d", j), int'(tick10), 0);
      // stop arrives in the cycle that registers the tick
      if (j == 5) run10 = 1'b1;
    end
    @(negedge clk);
    run10 = 1'b0;
    check("pending_tick", int'(tick10), 1);
    check("pending_run", int'(orun10), 0);
    @(negedge clk);
    check("pending_msec", int'(msec10), 1);
    // Simultaneous run + clear while stopped: clear wins
    run10 = 1'b1;
    clr10 = 1'b1;
    @(negedge clk);
    run10 = 1'b0;
    clr10 = 1'b0;
    check("runclr_run_a", int'(orun10), 0);
    @(negedge clk);
    check("runclr_run_b", int'(orun10), 0);
    check("runclr_msec", int'(msec10), 0);

    // Full wrap on reduced moduli (4/3/3)
    runs = 1'b1;
    @(negedge clk);
    runs = 1'b0;
    wait_vals(1, 3, 0, 0, 200, "us_003");
    step_expect(1, 0, 1, 0, "us_msec_wrap");
    wait_vals(1, 3, 2, 0, 200, "us_023");
    step_expect(1, 0, 0, 1, "us_sec_wrap");
    wait_vals(1, 3, 2, 2, 200, "us_223");
    step_expect(1, 0, 0, 0, "us_full_wrap");

    // Default moduli, FCOUNT=2: async reset at 00:03.42
    run2 = 1'b1;
    @(negedge clk);
    run2 = 1'b0;
    wait_vals(0, 99, 0, 0, 400, "u2_0099");
    step_expect(0, 0, 1, 0, "u2_0100");
    wait_vals(0, 42, 3, 0, 1000, "u2_0342");
    #2;
    reset = 1'b0;
    #1;
    check("async_counts", int'({msec2, sec2, min2}), 0);
    check("async_run", int'(orun2), 0);
    check("async_tick", int'(tick2), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_quiet", int'({msec2, orun2, tick2}), 0);
    end

    // 00:59.99 -> 01:00.00
    run2 = 1'b1;
    @(negedge clk);
    run2 = 1'b0;
    wait_vals(0, 99, 59, 0, 13000, "u2_5999");
    step_expect(0, 0, 0, 1, "u2_min_wrap");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
